// File: rtl/unidade_controle_multiciclo_if.sv
// rtl/unidade_controle_multiciclo_if.sv - control unit <-> datapath/memory signal bundle
interface unidade_controle_multiciclo_if;
    logic [7:0] Instrucao;
    logic       MemPronta;
    logic       EscrevePC;
    logic       FontePC;
    logic       EscreveIR;
    logic       LeMem;
    logic       EscreveMem;
    logic       EscreveReg;
    logic [1:0] OpULA;
    logic       Bit1Selecao;
    logic       Bit2Selecao;
    logic       Parado;
    logic       Erro;

    modport master (
        input  Instrucao, MemPronta,
        output EscrevePC, FontePC, EscreveIR, LeMem, EscreveMem, EscreveReg,
               OpULA, Bit1Selecao, Bit2Selecao, Parado, Erro
    );

    modport slave (
        output Instrucao, MemPronta,
        input  EscrevePC, FontePC, EscreveIR, LeMem, EscreveMem, EscreveReg,
               OpULA, Bit1Selecao, Bit2Selecao, Parado, Erro
    );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// rtl/unidade_controle_multiciclo.sv - multicycle control FSM for the 8-bit nRisc core
module unidade_controle_multiciclo #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                            Clock,
    input  logic                            Reset,
    unidade_controle_multiciclo_if.master   bus
);
    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        PARADO     = 3'd5
    } estado_t;

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_LI = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100, OP_SW  = 3'b101, OP_JAL = 3'b110, OP_HALT = 3'b111;
    localparam logic [7:0] LIMITE = 8'(TIMEOUT - 1);

    estado_t    estado, proximo;
    logic [2:0] op;
    logic [7:0] espera;
    logic       erro;
    logic       esgotou;

    // Reaching LIMITE with no ready means this is the TIMEOUT-th idle MEMORIA cycle.
    assign esgotou = (estado == MEMORIA) && !bus.MemPronta && (espera == LIMITE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado <= BUSCA;
            op     <= 3'b000;
            espera <= 8'd0;
            erro   <= 1'b0;
        end else begin
            estado <= proximo;
            if (estado == BUSCA)
                op <= bus.Instrucao[7:5];
            if (estado == MEMORIA && !bus.MemPronta)
                espera <= espera + 8'd1;
            else
                espera <= 8'd0;
            if (esgotou)
                erro <= 1'b1;
        end
    end

    always_comb begin
        proximo         = estado;
        bus.EscrevePC   = 1'b0;
        bus.FontePC     = 1'b0;
        bus.EscreveIR   = 1'b0;
        bus.LeMem       = 1'b0;
        bus.EscreveMem  = 1'b0;
        bus.EscreveReg  = 1'b0;
        bus.OpULA       = 2'b00;
        bus.Bit1Selecao = 1'b0;
        bus.Bit2Selecao = 1'b0;
        bus.Parado      = 1'b0;
        bus.Erro        = erro;

        case (estado)
            BUSCA: begin
                bus.EscreveIR = 1'b1;
                bus.EscrevePC = 1'b1;
                proximo       = DECODIFICA;
            end
            DECODIFICA: begin
                case (op)
                    OP_LI, OP_JAL: proximo = ESCRITA;
                    OP_HALT:       proximo = PARADO;
                    default:       proximo = EXECUTA;
                endcase
            end
            EXECUTA: begin
                case (op)
                    OP_SUB:  bus.OpULA = 2'b01;
                    OP_AND:  bus.OpULA = 2'b10;
                    default: bus.OpULA = 2'b00;
                endcase
                proximo = (op == OP_LW || op == OP_SW) ? MEMORIA : ESCRITA;
            end
            MEMORIA: begin
                bus.LeMem      = (op == OP_LW);
                bus.EscreveMem = (op == OP_SW);
                // A completing ready wins over a timeout on the same cycle.
                if (bus.MemPronta)
                    proximo = (op == OP_LW) ? ESCRITA : BUSCA;
                else if (esgotou)
                    proximo = PARADO;
            end
            ESCRITA: begin
                bus.EscreveReg = 1'b1;
                case (op)
                    OP_LW: bus.Bit1Selecao = 1'b1;
                    OP_LI: bus.Bit2Selecao = 1'b1;
                    OP_JAL: begin
                        bus.Bit1Selecao = 1'b1;
                        bus.Bit2Selecao = 1'b1;
                        bus.EscrevePC   = 1'b1;
                        bus.FontePC     = 1'b1;
                    end
                    default: ;
                endcase
                proximo = BUSCA;
            end
            PARADO: begin
                bus.Parado = 1'b1;
            end
            default: proximo = BUSCA;
        endcase
    end
endmodule

// File: doc/unidade_controle_multiciclo.md
# unidade_controle_multiciclo

Multicycle control FSM for the 8-bit nRisc datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It generates the datapath strobes and drives the two select bits of the 4:1 write-back multiplexer, which sits directly downstream and chooses the register-file write data. It also handles a ready handshake with data memory and stops the core on HALT or a memory timeout.

## Interface
- TIMEOUT, 15: maximum MEMORIA cycles without MemPronta before the error stop; range 1..255.
- Clock  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clock.
- Instrucao  in  8  instruction word from the IR input side; opcode = Instrucao[7:5].
- MemPronta  in  1  data memory ready; completes the current read or write.
- EscrevePC  out  1  PC load strobe.
- FontePC  out  1  0 = PC+1, 1 = jump target.
- EscreveIR  out  1  IR load strobe.
- LeMem  out  1  data memory read request.
- EscreveMem  out  1  data memory write request.
- EscreveReg  out  1  register-file write strobe.
- OpULA  out  2  00 add, 01 sub, 10 and.
- Bit1Selecao  out  1  write-back mux select LSB.
- Bit2Selecao  out  1  write-back mux select MSB.
- Parado  out  1  core stopped.
- Erro  out  1  stop was caused by a memory timeout.

## Operation
- States: BUSCA, DECODIFICA, EXECUTA, MEMORIA, ESCRITA, PARADO; 3-bit encoding.
- The opcode register Op[2:0] loads Instrucao[7:5] on the edge that leaves BUSCA. All later decisions use Op, never the live Instrucao.
- BUSCA: EscreveIR=1, EscrevePC=1, FontePC=0. Next state is DECODIFICA.
- DECODIFICA: no strobes asserted. Next state depends on Op:
  - 000/001/010/100/101 go to EXECUTA.
  - 011 (LI) and 110 (JAL) go to ESCRITA.
  - 111 (HALT) goes to PARADO with Erro=0.
- EXECUTA: OpULA = 00/01/10 for Op 000/001/010; OpULA = 00 for LW and SW (address add). ALU ops go to ESCRITA; LW/SW go to MEMORIA.
- MEMORIA:
  - LeMem=1 for LW, EscreveMem=1 for SW. The request is held until MemPronta=1.
  - On MemPronta, LW goes to ESCRITA and SW goes to BUSCA.
  - Wait counter Espera (8 bits) clears on entry to MEMORIA and increments each cycle MemPronta=0.
  - When Espera reaches TIMEOUT with MemPronta still 0, the FSM goes to PARADO with Erro=1.
  - MemPronta takes priority over timeout on the same cycle.
- ESCRITA: EscreveReg=1 for one cycle. Write-back select {Bit2Selecao,Bit1Selecao}:
  - 00 = ALU result (ADD/SUB/AND)
  - 01 = memory data (LW)
  - 10 = immediate (LI)
  - 11 = PC+1 (JAL)
  - JAL also asserts EscrevePC=1 with FontePC=1 in the same cycle.
  - Next state is BUSCA.
- PARADO: all strobes 0 and Parado=1. The FSM stays here until Reset; Erro holds its value.
- Strobes and OpULA are Moore outputs decoded from state and Op. The select bits are 00 outside ESCRITA.
- MemPronta is ignored outside MEMORIA.

## Timing
- Reset produces, on the next edge: state BUSCA, Op=000, Espera=0, Erro=0. All outputs read 0 in that cycle except EscreveIR=1 and EscrevePC=1, which are the BUSCA outputs.
- Reset mid-instruction, including inside MEMORIA, aborts without completing the write. It overrides MemPronta and timeout.
- Cycles per instruction:
  - ADD/SUB/AND: 4
  - LI: 3
  - JAL: 3
  - LW: 5 + n
  - SW: 4 + n
  - n = MemPronta wait cycles.
- MemPronta present on the first MEMORIA cycle gives n=0.
- The timeout edge occurs after exactly TIMEOUT MEMORIA cycles with MemPronta=0.
- Each strobe lasts exactly one cycle per instruction, except LeMem/EscreveMem, which last 1+n cycles.

## Test plan
- Reset, then ADD (Instrucao=8'h00 in BUSCA): states B,D,E,W over 4 cycles. OpULA=00 in EXECUTA; EscreveReg=1 with sel 00 in ESCRITA; back in BUSCA on cycle 5.
- LW (8'h80) with MemPronta raised on the 3rd MEMORIA cycle: LeMem high for 3 cycles, then ESCRITA with sel 01. Total 7 cycles.
- SW (8'hA0), MemPronta never asserted, TIMEOUT=15: EscreveMem high for 15 cycles, then Parado=1 and Erro=1. No EscreveReg at any point.
- JAL (8'hC0): ESCRITA on cycle 3 with sel 11, EscreveReg=1, EscrevePC=1, FontePC=1. LI (8'h60): sel 10 on cycle 3.
- HALT (8'hE0): Parado=1 and Erro=0 from cycle 3. Instrucao changes and MemPronta toggles are ignored. Reset returns to BUSCA on the next edge.
- Reset asserted in MEMORIA on the same cycle as MemPronta=1: next state is BUSCA, EscreveReg never pulses, and Erro=0.
